// File: rtl/yarvi_me_arb.sv
// Shares the single load/store unit between the core (port A) and the host loader (port B):
// one tagged issue per cycle, 1-cycle response routed to its owner, load-hit-store replay.
module yarvi_me_arb #(
  parameter int STARVE_LIMIT = 8,
  parameter int CNT_W        = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        a_valid,
  output logic        a_ready,
  input  logic [31:0] a_addr,
  input  logic        a_we,
  input  logic        a_re,
  input  logic [2:0]  a_funct3,
  input  logic [31:0] a_wdata,
  output logic        a_rsp_valid,
  output logic [31:0] a_rsp_data,
  output logic        a_rsp_err,
  input  logic        b_valid,
  output logic        b_ready,
  input  logic [31:0] b_addr,
  input  logic        b_we,
  input  logic        b_re,
  input  logic [2:0]  b_funct3,
  input  logic [31:0] b_wdata,
  output logic        b_rsp_valid,
  output logic [31:0] b_rsp_data,
  output logic        b_rsp_err,
  output logic        me_valid,
  output logic [31:0] me_addr,
  output logic        me_we,
  output logic        me_re,
  output logic [2:0]  me_funct3,
  output logic [31:0] me_wdata,
  input  logic        mu_valid,
  input  logic [31:0] mu_data,
  input  logic        mu_misaligned,
  input  logic        mu_lhs
);

  logic [CNT_W-1:0] starve_cnt_reg, starve_cnt_next;
  logic             tag_vld_reg;
  logic             replay_pend_reg;   // the access in flight is itself a replay
  logic             iss_owner_reg;     // 0 = A, 1 = B
  logic [31:0]      iss_addr_reg;
  logic             iss_we_reg;
  logic             iss_re_reg;
  logic [2:0]       iss_funct3_reg;
  logic [31:0]      iss_wdata_reg;
  logic             a_rsp_valid_reg, b_rsp_valid_reg;
  logic [31:0]      rsp_data_reg;
  logic             rsp_err_reg;

  logic        replay_now, rsp_fire, rsp_err;
  logic [31:0] rsp_data;
  logic        b_pri, grant_a, grant_b, issue;

  // Decode the unit's answer for the access issued last cycle.
  always_comb begin
    replay_now = 1'b0;
    rsp_fire   = 1'b0;
    rsp_err    = 1'b0;
    rsp_data   = mu_data;
    if (tag_vld_reg) begin
      if (!mu_valid || mu_misaligned) begin
        rsp_fire = 1'b1;
        rsp_err  = 1'b1;
        rsp_data = iss_addr_reg;
      end else if (mu_lhs && iss_re_reg && !replay_pend_reg) begin
        replay_now = 1'b1;
      end else if (mu_lhs && replay_pend_reg) begin
        rsp_fire = 1'b1;
        rsp_err  = 1'b1;
        rsp_data = iss_addr_reg;
      end else begin
        rsp_fire = 1'b1;
      end
    end
  end

  assign b_pri   = (starve_cnt_reg == CNT_W'(STARVE_LIMIT));
  assign grant_b = !reset && !replay_now && b_valid && (b_pri || !a_valid);
  assign grant_a = !reset && !replay_now && a_valid && !grant_b;
  assign issue   = grant_a || grant_b || (replay_now && !reset);

  assign a_ready  = grant_a;
  assign b_ready  = grant_b;
  assign me_valid = issue;

  always_comb begin
    me_addr   = a_addr;
    me_we     = a_we;
    me_re     = a_re;
    me_funct3 = a_funct3;
    me_wdata  = a_wdata;
    if (replay_now) begin
      me_addr   = iss_addr_reg;
      me_we     = iss_we_reg;
      me_re     = iss_re_reg;
      me_funct3 = iss_funct3_reg;
      me_wdata  = iss_wdata_reg;
    end else if (grant_b) begin
      me_addr   = b_addr;
      me_we     = b_we;
      me_re     = b_re;
      me_funct3 = b_funct3;
      me_wdata  = b_wdata;
    end
  end

  // Saturating count of consecutive cycles B waited; replay cycles count as waits.
  always_comb begin
    starve_cnt_next = '0;
    if (b_valid && !grant_b)
      starve_cnt_next = b_pri ? starve_cnt_reg : starve_cnt_reg + CNT_W'(1);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      starve_cnt_reg  <= '0;
      tag_vld_reg     <= 1'b0;
      replay_pend_reg <= 1'b0;
      a_rsp_valid_reg <= 1'b0;
      b_rsp_valid_reg <= 1'b0;
    end else begin
      starve_cnt_reg  <= starve_cnt_next;
      tag_vld_reg     <= issue;
      replay_pend_reg <= replay_now;
      a_rsp_valid_reg <= rsp_fire && !iss_owner_reg;
      b_rsp_valid_reg <= rsp_fire && iss_owner_reg;
    end
  end

  // A replay re-drives the latched request, so only fresh grants reload it.
  always_ff @(posedge clock) begin
    if (grant_a || grant_b) begin
      iss_owner_reg  <= grant_b;
      iss_addr_reg   <= me_addr;
      iss_we_reg     <= me_we;
      iss_re_reg     <= me_re;
      iss_funct3_reg <= me_funct3;
      iss_wdata_reg  <= me_wdata;
    end
    if (rsp_fire) begin
      rsp_data_reg <= rsp_data;
      rsp_err_reg  <= rsp_err;
    end
  end

  assign a_rsp_valid = a_rsp_valid_reg;
  assign b_rsp_valid = b_rsp_valid_reg;
  assign a_rsp_data  = rsp_data_reg;
  assign b_rsp_data  = rsp_data_reg;
  assign a_rsp_err   = rsp_err_reg;
  assign b_rsp_err   = rsp_err_reg;

endmodule

// File: tb/tb_yarvi_me_arb.sv
// Bench for yarvi_me_arb: arbitration table, hand-written replay/misalign/reset sequences,
// then random traffic against a transaction-level model of the arbiter and memory unit.
module tb_yarvi_me_arb;
  localparam int STARVE_LIMIT = 8;

  typedef struct packed {
    logic        v;
    logic        we;
    logic        re;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
  } req_t;

  typedef struct {
    logic av;
    logic bv;
    logic ar;
    logic br;
  } vec_t;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  req_t a_req, b_req;
  logic a_ready, b_ready, a_rsp_valid, b_rsp_valid, a_rsp_err, b_rsp_err;
  logic [31:0] a_rsp_data, b_rsp_data;
  logic me_valid, me_we, me_re;
  logic [31:0] me_addr, me_wdata;
  logic [2:0] me_funct3;
  logic mu_valid, mu_misaligned, mu_lhs;
  logic [31:0] mu_data;

  yarvi_me_arb #(.STARVE_LIMIT(STARVE_LIMIT), .CNT_W(4)) dut (
    .clock(clock), .reset(reset),
    .a_valid(a_req.v), .a_ready(a_ready), .a_addr(a_req.addr), .a_we(a_req.we),
    .a_re(a_req.re), .a_funct3(a_req.f3), .a_wdata(a_req.wdata),
    .a_rsp_valid(a_rsp_valid), .a_rsp_data(a_rsp_data), .a_rsp_err(a_rsp_err),
    .b_valid(b_req.v), .b_ready(b_ready), .b_addr(b_req.addr), .b_we(b_req.we),
    .b_re(b_req.re), .b_funct3(b_req.f3), .b_wdata(b_req.wdata),
    .b_rsp_valid(b_rsp_valid), .b_rsp_data(b_rsp_data), .b_rsp_err(b_rsp_err),
    .me_valid(me_valid), .me_addr(me_addr), .me_we(me_we), .me_re(me_re),
    .me_funct3(me_funct3), .me_wdata(me_wdata),
    .mu_valid(mu_valid), .mu_data(mu_data), .mu_misaligned(mu_misaligned), .mu_lhs(mu_lhs)
  );

  int checks = 0;
  int errors = 0;

  // Model: the access the unit is working on, who owns it, whether it is a replay.
  req_t        inf;
  logic        inf_v, inf_owner, inf_replay;
  int          starve;
  logic [31:0] last_mu_data;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic misal(input req_t r);
    case (r.f3[1:0])
      2'd0:    return 1'b0;
      2'd1:    return r.addr[0];
      default: return r.addr[1:0] != 2'b00;
    endcase
  endfunction

  function automatic req_t mk(input logic we, input logic [2:0] f3, input logic [31:0] addr);
    req_t r;
    r.v = 1'b1; r.we = we; r.re = !we; r.f3 = f3; r.addr = addr; r.wdata = $urandom;
    return r;
  endfunction

  function automatic req_t rnd_req();
    logic [2:0]  f3s [4] = '{3'd0, 3'd1, 3'd2, 3'd4};
    logic [31:0] a;
    a = 32'h8000_0000 | ($urandom & 32'h0000_0FFC);
    if ($urandom_range(0, 5) == 0) a = a | 32'($urandom_range(1, 3));
    return mk($urandom_range(0, 2) == 0, f3s[$urandom_range(0, 3)], a);
  endfunction

  // One clock: drive the unit's answer, predict grants/issue/response, compare, advance.
  task automatic do_cycle(input logic lhs_k, input logic drop_k);
    logic rep, fire, err, ga, gb, iv;
    req_t is;
    mu_valid      = inf_v && !drop_k;
    mu_data       = $urandom;
    mu_misaligned = mu_valid && misal(inf);
    mu_lhs        = mu_valid && lhs_k && inf.re && !inf_replay;
    last_mu_data  = mu_data;
    rep  = mu_lhs && !mu_misaligned;
    fire = inf_v && !rep;
    err  = !mu_valid || mu_misaligned;
    gb   = !rep && b_req.v && (starve == STARVE_LIMIT || !a_req.v);
    ga   = !rep && a_req.v && !gb;
    iv   = rep || ga || gb;
    is   = rep ? inf : (gb ? b_req : a_req);
    #1;
    chk("a_ready", a_ready, ga);
    chk("b_ready", b_ready, gb);
    chk("me_valid", me_valid, iv);
    if (iv) begin
      chk("me_addr", me_addr, is.addr);
      chk("me_we", me_we, is.we);
      chk("me_re", me_re, is.re);
      chk("me_funct3", me_funct3, is.f3);
      if (is.we) chk("me_wdata", me_wdata, is.wdata);
    end
    @(posedge clock); #1;
    chk("a_rsp_valid", a_rsp_valid, fire && !inf_owner);
    chk("b_rsp_valid", b_rsp_valid, fire && inf_owner);
    if (fire) begin
      chk("rsp_err", inf_owner ? b_rsp_err : a_rsp_err, err);
      if ((err && mu_valid) || (!err && inf.re))
        chk("rsp_data", inf_owner ? b_rsp_data : a_rsp_data, err ? inf.addr : last_mu_data);
    end
    starve = (b_req.v && !gb) ? ((starve < STARVE_LIMIT) ? starve + 1 : starve) : 0;
    if (!rep) begin
      inf       = is;
      inf_owner = gb;
    end
    inf_replay = rep;
    inf_v      = iv;
    if (ga) a_req.v = 1'b0;
    if (gb) b_req.v = 1'b0;
    @(negedge clock);
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    for (int i = 0; i < n; i++) begin
      mu_valid = 1'b1; mu_lhs = 1'b1; mu_misaligned = 1'b0; mu_data = $urandom;
      #1;
      chk("rst_a_ready", a_ready, 1'b0);
      chk("rst_b_ready", b_ready, 1'b0);
      chk("rst_me_valid", me_valid, 1'b0);
      @(posedge clock); #1;
      chk("rst_a_rsp_valid", a_rsp_valid, 1'b0);
      chk("rst_b_rsp_valid", b_rsp_valid, 1'b0);
      @(negedge clock);
    end
    reset = 1'b0;
    inf_v = 1'b0; inf_replay = 1'b0; inf_owner = 1'b0; starve = 0; inf = '0;
  endtask

  vec_t tbl[$];

  initial begin
    a_req = '0; b_req = '0;
    mu_valid = 1'b0; mu_data = '0; mu_misaligned = 1'b0; mu_lhs = 1'b0;
    a_req.v = 1'b1; b_req.v = 1'b1;
    do_reset(2);
    a_req.v = 1'b0; b_req.v = 1'b0;

    // Single A load: ready on issue, data two edges later.
    a_req = mk(1'b0, 3'd2, 32'h8000_0010);
    do_cycle(1'b0, 1'b0);
    do_cycle(1'b0, 1'b0);
    chk("t1_rsp_valid", a_rsp_valid, 1'b1);
    chk("t1_rsp_data", a_rsp_data, last_mu_data);
    chk("t1_rsp_err", a_rsp_err, 1'b0);

    // B misaligned word load returns the faulting address.
    b_req = mk(1'b0, 3'd2, 32'h8000_0002);
    do_cycle(1'b0, 1'b0);
    do_cycle(1'b0, 1'b0);
    chk("t4_b_err", b_rsp_err, 1'b1);
    chk("t4_b_data", b_rsp_data, 32'h8000_0002);
    chk("t4_no_a_rsp", a_rsp_valid, 1'b0);

    // Store then load to the same word; the load is killed once and replayed.
    a_req = mk(1'b1, 3'd2, 32'h8000_0020);
    do_cycle(1'b0, 1'b0);
    a_req = mk(1'b0, 3'd2, 32'h8000_0020);
    do_cycle(1'b0, 1'b0);
    b_req = mk(1'b0, 3'd2, 32'h8000_0100);
    do_cycle(1'b1, 1'b0);
    chk("t3_no_rsp_on_kill", a_rsp_valid, 1'b0);
    do_cycle(1'b0, 1'b0);
    chk("t3_replay_rsp", a_rsp_valid, 1'b1);
    chk("t3_replay_data", a_rsp_data, last_mu_data);
    do_cycle(1'b0, 1'b0);
    chk("t3_single_a_rsp", a_rsp_valid, 1'b0);

    // Reset right after an issue: the response is discarded.
    a_req = mk(1'b0, 3'd2, 32'h8000_0040);
    do_cycle(1'b0, 1'b0);
    a_req = mk(1'b0, 3'd2, 32'h8000_0044);
    b_req = mk(1'b0, 3'd2, 32'h8000_0048);
    do_reset(1);
    a_req.v = 1'b0; b_req.v = 1'b0;
    do_cycle(1'b0, 1'b0);

    // Arbitration table, starting from a cleared starve counter.
    for (int i = 0; i < 8; i++) tbl.push_back('{1'b1, 1'b1, 1'b1, 1'b0});
    tbl.push_back('{1'b1, 1'b1, 1'b0, 1'b1});
    tbl.push_back('{1'b1, 1'b1, 1'b1, 1'b0});
    tbl.push_back('{1'b1, 1'b1, 1'b1, 1'b0});
    tbl.push_back('{1'b0, 1'b1, 1'b0, 1'b1});
    tbl.push_back('{1'b1, 1'b0, 1'b1, 1'b0});
    tbl.push_back('{1'b0, 1'b1, 1'b0, 1'b1});
    tbl.push_back('{1'b1, 1'b0, 1'b1, 1'b0});
    tbl.push_back('{1'b0, 1'b1, 1'b0, 1'b1});
    tbl.push_back('{1'b0, 1'b0, 1'b0, 1'b0});
    for (int i = 0; i < tbl.size(); i++) begin
      if (tbl[i].av && !a_req.v) a_req = rnd_req();
      if (!tbl[i].av) a_req.v = 1'b0;
      if (tbl[i].bv && !b_req.v) b_req = rnd_req();
      if (!tbl[i].bv) b_req.v = 1'b0;
      #1;
      chk($sformatf("tbl%0d_a_ready", i), a_ready, tbl[i].ar);
      chk($sformatf("tbl%0d_b_ready", i), b_ready, tbl[i].br);
      #1;
      do_cycle(1'b0, 1'b0);
    end

    // Random traffic with occasional kills and dropped responses.
    for (int i = 0; i < 400; i++) begin
      if (!a_req.v && $urandom_range(0, 3) != 0) a_req = rnd_req();
      if (!b_req.v && $urandom_range(0, 2) == 0) b_req = rnd_req();
      do_cycle($urandom_range(0, 2) == 0, $urandom_range(0, 39) == 0);
    end
    a_req.v = 1'b0; b_req.v = 1'b0;
    do_cycle(1'b0, 1'b0);
    do_cycle(1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
